// File: rtl/bias_stream_sched_pkg.sv
// Shared definitions for the bias stream sequencer.
// - Default bias word width and per-layer channel/repeat counts.
// - FSM state encodings (IDLE, RUN, DRAIN).
// - Counter width helper that never returns less than one bit.
package bias_stream_sched_pkg;

  localparam int COEFF_WIDTH_DEF = 16;
  localparam int NUM_CH_DEF      = 32;
  localparam int NUM_REPEAT_DEF  = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Width needed to count 0..n-1, at least one bit so a single-entry
  // counter still has a real signal behind it.
  function automatic int cnt_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/bias_stream_sched_skid_fifo2.sv
// Two-entry registered FIFO used as the skid buffer between the ROM read
// port and the output stream.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   push, din  : write a word at the tail (ignored when full without pop)
//   pop        : remove the head word (ignored when empty)
//   occ        : current occupancy 0..2
//   head       : oldest word, always taken straight from a register
module bias_stream_sched_skid_fifo2
  import bias_stream_sched_pkg::*;
#(
  parameter int W = COEFF_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);

  logic [W-1:0] mem0_q, mem0_d;
  logic [W-1:0] mem1_q, mem1_d;
  logic [1:0]   occ_q, occ_d;

  // Next-state for the two slots; mem0 is always the head so a pop shifts
  // mem1 forward, and a simultaneous push/pop keeps occupancy and order.
  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    occ_d  = occ_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          mem0_d = din;
          occ_d  = 2'd1;
        end else begin
          occ_d = 2'd0;
        end
      end
      2'd1: begin
        if (push && pop) begin
          mem0_d = din;
        end else if (push) begin
          mem1_d = din;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d = 2'd0;
        end else begin
          occ_d = 2'd1;
        end
      end
      2'd2: begin
        if (pop) begin
          mem0_d = mem1_q;
          if (push) begin
            mem1_d = din;
          end else begin
            occ_d = 2'd1;
          end
        end else begin
          occ_d = 2'd2;
        end
      end
      default: begin
        occ_d = 2'd0;
      end
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q <= '0;
      mem1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      occ_q  <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = mem0_q;

endmodule

// File: rtl/bias_stream_sched.sv
// Bias stream sequencer: on ap_start, reads the NUM_CH-entry bias ROM
// NUM_REPEAT times in channel order and writes every word into the
// downstream stream FIFO, then pulses ap_done.
// Ports:
//   ap_clk, ap_rst_n            : clock, asynchronous active-low reset
//   ap_start / ap_done / ap_idle: block-level handshake
//   bias_address, bias_ce, bias_q: registered ROM port (1-cycle latency)
//   output_V_din/_write/_full_n : output stream with back-pressure
module bias_stream_sched
  import bias_stream_sched_pkg::*;
#(
  parameter int COEFF_WIDTH = COEFF_WIDTH_DEF,
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int NUM_REPEAT  = NUM_REPEAT_DEF,
  parameter int ADDR_W      = cnt_width(NUM_CH)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   ap_start,
  output logic                   ap_done,
  output logic                   ap_idle,
  output logic [ADDR_W-1:0]      bias_address,
  output logic                   bias_ce,
  input  logic [COEFF_WIDTH-1:0] bias_q,
  output logic [COEFF_WIDTH-1:0] output_V_din,
  input  logic                   output_V_full_n,
  output logic                   output_V_write
);

  localparam int RP_W = cnt_width(NUM_REPEAT);
  localparam logic [ADDR_W-1:0] CH_LAST = ADDR_W'(NUM_CH - 1);
  localparam logic [RP_W-1:0]   RP_LAST = RP_W'(NUM_REPEAT - 1);

  logic [1:0]             state_q, state_d;
  logic [ADDR_W-1:0]      ch_q, ch_d;
  logic [RP_W-1:0]        rp_q, rp_d;
  logic                   inflight_q, inflight_d;
  logic [1:0]             occ;
  logic [COEFF_WIDTH-1:0] head;
  logic                   pop;
  logic                   issue;
  logic                   done;
  logic [2:0]             credit_used;
  logic [2:0]             credit_avail;

  // Credit check: words buffered plus the word still coming back from the
  // ROM must leave room, counting the slot freed by this cycle's pop.
  always_comb begin
    pop          = (occ != 2'd0) && output_V_full_n;
    credit_used  = {1'b0, occ} + {2'b00, inflight_q};
    credit_avail = 3'd2 + {2'b00, pop};
    if ((state_q == ST_RUN) && (credit_used < credit_avail)) begin
      issue = 1'b1;
    end else begin
      issue = 1'b0;
    end
  end

  // Sequencer FSM and channel/repeat counters.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    rp_d       = rp_q;
    done       = 1'b0;
    inflight_d = issue;
    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          state_d = ST_RUN;
          ch_d    = '0;
          rp_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue) begin
          if (ch_q == CH_LAST) begin
            ch_d = '0;
            if (rp_q == RP_LAST) begin
              rp_d    = '0;
              state_d = ST_DRAIN;
            end else begin
              rp_d = rp_q + RP_W'(1);
            end
          end else begin
            ch_d = ch_q + ADDR_W'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Done only once the last ROM word has landed and been written out.
        if ((occ == 2'd0) && !inflight_q) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      rp_q       <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      rp_q       <= rp_d;
      inflight_q <= inflight_d;
    end
  end

  bias_stream_sched_skid_fifo2 #(
    .W (COEFF_WIDTH)
  ) u_skid (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (inflight_q),
    .din   (bias_q),
    .pop   (pop),
    .occ   (occ),
    .head  (head)
  );

  assign bias_ce        = issue;
  assign bias_address   = ch_q;
  assign output_V_write = pop;
  assign output_V_din   = head;
  assign ap_done        = done;
  assign ap_idle        = (state_q == ST_IDLE);

endmodule

// File: tb/tb_bias_stream_sched.sv
// Directed bench for bias_stream_sched: two instances (4x3 and 1x5) fed by
// registered ROM models; a per-cycle monitor tallies stream order, address
// order, back-pressure violations and handshake timing.
module tb_bias_stream_sched;

  logic        clk;
  logic        rst_n;
  logic        full_n;
  logic        a_start, b_start;
  logic        a_done, a_idle, a_ce, a_write;
  logic        b_done, b_idle, b_ce, b_write;
  logic [1:0]  a_addr;
  logic [0:0]  b_addr;
  logic [15:0] a_q, b_q, a_din, b_din;

  logic        sel;
  logic        m_write, m_ce, m_done, m_idle;
  logic [1:0]  m_addr;
  logic [15:0] m_din;

  int checks;
  int failures;
  int cyc;
  int wr_cnt, rd_cnt, done_cnt, data_err, addr_err, wr_full0, wr_stall;
  int max_out, late_done, first_wr, last_wr, first_done, last_done, ce9;

  bias_stream_sched #(.COEFF_WIDTH(16), .NUM_CH(4), .NUM_REPEAT(3)) dut_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(a_start), .ap_done(a_done),
    .ap_idle(a_idle), .bias_address(a_addr), .bias_ce(a_ce), .bias_q(a_q),
    .output_V_din(a_din), .output_V_full_n(full_n), .output_V_write(a_write)
  );

  bias_stream_sched #(.COEFF_WIDTH(16), .NUM_CH(1), .NUM_REPEAT(5)) dut_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(b_start), .ap_done(b_done),
    .ap_idle(b_idle), .bias_address(b_addr), .bias_ce(b_ce), .bias_q(b_q),
    .output_V_din(b_din), .output_V_full_n(full_n), .output_V_write(b_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM models: A holds {10,11,12,13}, B holds {7}.
  always @(posedge clk) begin
    if (a_ce) a_q <= 16'd10 + {14'd0, a_addr};
    if (b_ce) b_q <= 16'd7;
  end

  assign m_write = sel ? b_write : a_write;
  assign m_ce    = sel ? b_ce    : a_ce;
  assign m_done  = sel ? b_done  : a_done;
  assign m_idle  = sel ? b_idle  : a_idle;
  assign m_addr  = sel ? {1'b0, b_addr} : a_addr;
  assign m_din   = sel ? b_din   : a_din;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // mode: 0 = full_n always 1, 1 = full_n low in cycles 5..9, 2 = random.
  task automatic run_seq(input bit sel_i, input int mode, input bit hold,
                         input int runs, input int nch, input int base, input int max_cyc);
    int outstanding;
    sel = sel_i;
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; data_err = 0; addr_err = 0;
    wr_full0 = 0; wr_stall = 0; max_out = 0; late_done = 0;
    first_wr = -1; last_wr = -1; first_done = -1; last_done = -1; ce9 = -1;
    @(posedge clk); #1;
    cyc = 0;
    if (sel_i) b_start = 1'b1; else a_start = 1'b1;
    while (done_cnt < runs && cyc < max_cyc) begin
      case (mode)
        1: full_n = !(cyc >= 5 && cyc <= 9);
        2: full_n = ($urandom_range(0, 1) == 1);
        default: full_n = 1'b1;
      endcase
      @(negedge clk);
      outstanding = rd_cnt - wr_cnt;
      if (outstanding > max_out) max_out = outstanding;
      if (m_write) begin
        if (!full_n) wr_full0++;
        if (mode == 1 && cyc >= 5 && cyc <= 9) wr_stall++;
        if (int'(m_din) != base + (wr_cnt % nch)) data_err++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        wr_cnt++;
      end
      if (m_ce) begin
        if (int'(m_addr) != (rd_cnt % nch)) addr_err++;
        rd_cnt++;
      end
      if (cyc == 9) ce9 = int'(m_ce);
      if (m_done) begin
        if (cyc != last_wr + 1) late_done++;
        if (first_done < 0) first_done = cyc;
        last_done = cyc;
        done_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
      if (!hold) begin a_start = 1'b0; b_start = 1'b0; end
    end
    a_start = 1'b0; b_start = 1'b0; full_n = 1'b1;
    @(negedge clk);
    check_eq("idle_after_done", {31'd0, m_idle}, 32'd1);
    check_eq("done_count", done_cnt, runs);
  endtask

  task automatic check_stream(input string tag, input int exp_writes);
    check_eq({tag, "_writes"}, wr_cnt, exp_writes);
    check_eq({tag, "_data_err"}, data_err, 0);
    check_eq({tag, "_addr_err"}, addr_err, 0);
    check_eq({tag, "_write_full0"}, wr_full0, 0);
    check_eq({tag, "_outstanding_le2"}, {31'd0, (max_out <= 2)}, 32'd1);
    check_eq({tag, "_done_after_last"}, late_done, 0);
  endtask

  initial begin
    int n;
    checks = 0; failures = 0;
    sel = 1'b0; full_n = 1'b1; a_start = 1'b0; b_start = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ce",    {31'd0, a_ce},    32'd0);
    check_eq("rst_write", {31'd0, a_write}, 32'd0);
    check_eq("rst_done",  {31'd0, a_done},  32'd0);
    check_eq("rst_idle",  {31'd0, a_idle},  32'd1);
    check_eq("rst_addr",  {30'd0, a_addr},  32'd0);
    check_eq("rst_din",   {16'd0, a_din},   32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Nominal 4x3 run.
    run_seq(1'b0, 0, 1'b0, 1, 4, 10, 400);
    check_stream("nominal", 12);
    check_eq("nominal_first_write", first_wr, 3);
    check_eq("nominal_done_cycle", first_done, 15);

    // Back-pressure in cycles 5..9.
    run_seq(1'b0, 1, 1'b0, 1, 4, 10, 400);
    check_stream("stall", 12);
    check_eq("stall_no_write_5_9", wr_stall, 0);
    check_eq("stall_ce_low_c9", ce9, 0);
    check_eq("stall_first_write", first_wr, 3);
    check_eq("stall_done_cycle", first_done, 20);

    // Random back-pressure.
    run_seq(1'b0, 2, 1'b0, 1, 4, 10, 400);
    check_stream("random", 12);

    // Asynchronous reset after five writes.
    sel = 1'b0;
    @(posedge clk); #1;
    a_start = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 5; i++) begin
      @(negedge clk);
      if (a_write) n++;
      @(posedge clk); #1;
      a_start = 1'b0;
    end
    check_eq("midrst_setup_writes", n, 5);
    check_eq("midrst_pre_write", {31'd0, a_write}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_ce",    {31'd0, a_ce},    32'd0);
    check_eq("midrst_write", {31'd0, a_write}, 32'd0);
    check_eq("midrst_idle",  {31'd0, a_idle},  32'd1);
    check_eq("midrst_addr",  {30'd0, a_addr},  32'd0);
    check_eq("midrst_din",   {16'd0, a_din},   32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_seq(1'b0, 0, 1'b0, 1, 4, 10, 400);
    check_stream("after_rst", 12);
    check_eq("after_rst_first_write", first_wr, 3);

    // Start held high across two runs.
    run_seq(1'b0, 0, 1'b1, 2, 4, 10, 400);
    check_stream("hold", 24);
    check_eq("hold_first_done", first_done, 15);
    check_eq("hold_second_done", last_done, 31);

    // Single-channel instance.
    run_seq(1'b1, 0, 1'b0, 1, 1, 7, 400);
    check_stream("ch1", 5);
    check_eq("ch1_reads", rd_cnt, 5);
    check_eq("ch1_done_cycle", first_done, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bias_stream_sched.md
Name: bias_stream_sched

Overview:
- Sequencer that replays one layer's bias vector from a single-port registered bias ROM into the downstream bias stream FIFO.
- Emits the full vector of NUM_CH coefficients NUM_REPEAT times, one pass per output pixel, in channel order.
- Absorbs the 1-cycle ROM read latency and FIFO back-pressure with a 2-entry skid buffer.
- Sits between the rom instance and the conv/accumulate stage; it replaces a free-running bias reader with a start/done controlled one.

Parameters:
- COEFF_WIDTH, 16: bias word width.
- NUM_CH, 32: coefficients per pass (ROM depth used), >=1.
- NUM_REPEAT, 64: number of passes per start, >=1.
- ADDR_W, $clog2(NUM_CH) (minimum 1): ROM address width.

Ports:
- ap_clk  in  1  clock, all logic on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  level; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse after the final word is written.
- ap_idle  out  1  high in IDLE.
- bias_address  out  ADDR_W  ROM address.
- bias_ce  out  1  ROM read enable.
- bias_q  in  COEFF_WIDTH  ROM data, valid the cycle after bias_ce.
- output_V_din  out  COEFF_WIDTH  stream data.
- output_V_full_n  in  1  downstream has space.
- output_V_write  out  1  stream write strobe.

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - state=IDLE; counters, skid buffer and in-flight flag cleared.
  - bias_ce=0, output_V_write=0, ap_done=0, ap_idle=1, bias_address=0, output_V_din=0.
- FSM states are IDLE, RUN, DRAIN.
  - IDLE: ap_start=1 -> RUN; channel counter ch=0, repeat counter rp=0.
  - RUN: reads are issued. After the read with ch=NUM_CH-1 and rp=NUM_REPEAT-1 is issued -> DRAIN.
  - DRAIN: no reads. Waits until no read is in flight and the buffer is empty; then ap_done=1 for one cycle -> IDLE.
  - ap_start while in RUN/DRAIN is ignored. ap_start held high in IDLE right after done starts a new run.
- Read issue:
  - bias_ce=1 in RUN when (occ + inflight - pop) < 2.
  - occ = buffer occupancy (0..2); inflight = a read was issued last cycle; pop = output_V_write this cycle.
  - bias_address=ch.
  - Each issued read advances ch; ch wraps NUM_CH-1 -> 0 and increments rp on wrap.
- Capture: if inflight, bias_q is pushed into the buffer tail on the following edge. The credit rule guarantees it never overflows.
- Output:
  - output_V_write = (occ>0) & output_V_full_n.
  - output_V_din = buffer head, registered, not taken combinationally from bias_q.
  - Never assert write while full_n=0. Words are never dropped or duplicated, and order is preserved.
- Simultaneous push and pop in one cycle: occupancy unchanged, FIFO order kept.
- Latency: start sampled in cycle 0 -> ce/address 0 in cycle 1 -> q in cycle 2 -> first write in cycle 3 (full_n=1).
- Throughput: 1 word/cycle sustained while full_n=1.
- Total writes per start: exactly NUM_CH*NUM_REPEAT. ap_done fires the cycle after the last write.
- NUM_CH=1: address constantly 0, with one read per output word (no caching).

Decomposition:
- Shared package: COEFF_WIDTH default and per-layer NUM_CH/NUM_REPEAT constants (existing layer-size defines), plus the state enum {IDLE,RUN,DRAIN}.
- One natural sub-module: skid_fifo2, a 2-entry registered FIFO with push, pop, occ, and head outputs.
- The ROM is instantiated outside this block.

Test Plan:
- NUM_CH=4, NUM_REPEAT=3, ROM={10,11,12,13}, full_n=1, start pulse in cycle 0:
  - first write in cycle 3; stream 10,11,12,13 x3 on consecutive cycles (12 writes);
  - ap_done in cycle 15; ap_idle high from cycle 16.
- Same setup, full_n forced 0 during cycles 5-9:
  - no writes in 5-9; at most 2 words buffered;
  - bias_ce low once the credit is exhausted;
  - resumes with the correct next value; the 12-word sequence is intact.
- full_n toggling every cycle (random 50%):
  - output equals the expected sequence; exactly 12 writes; no write with full_n=0.
- ap_rst_n asserted asynchronously mid-RUN (after 5 writes):
  - outputs clear immediately with no clock edge;
  - after release, a new start gives a full 12-word stream from 10.
- ap_start held high for two runs:
  - the second run starts the cycle after done; 24 total writes; two ap_done pulses.
- NUM_CH=1, NUM_REPEAT=5, ROM={7}:
  - five writes of 7; bias_address stays 0; one ap_done.
